bitscan_encoder: RTL and testbench



---
 rtl/bitscan_pkg.sv | 32 +++
 rtl/bitscan_encoder_lsb_prio_enc.sv | 33 +++
 rtl/bitscan_encoder.sv | 116 +++++++++++
 tb/tb_bitscan_encoder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bitscan_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bitscan_pkg : shared types, defaults and popcount helper for bitscan_encoder
// Revision    : 1.0
// ----------------------------------------------------------------------------
package bitscan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        ZERO = 2'd2
    } bitscan_state_t;

    localparam int c_DEFAULT_WIDTH = 32;
    localparam int c_DEFAULT_IDX_W = $clog2(c_DEFAULT_WIDTH);

    // Popcount operates on a fixed wide vector; callers zero-extend and the
    // unused upper terms are constant-folded away.
    localparam int c_POP_MAX_W = 1024;
    localparam int c_POP_CNT_W = $clog2(c_POP_MAX_W) + 1;

    function automatic logic [c_POP_CNT_W-1:0] popcount(input logic [c_POP_MAX_W-1:0] vec);
        logic [c_POP_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < c_POP_MAX_W; i++) begin
            cnt = cnt + c_POP_CNT_W'(vec[i]);
        end
        return cnt;
    endfunction

endpackage : bitscan_pkg
`default_nettype wire

// File: rtl/bitscan_encoder_lsb_prio_enc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsb_prio_enc : combinational lowest-set-bit encoder with any/one-hot flags
// Revision     : 1.0
// ----------------------------------------------------------------------------
module lsb_prio_enc #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any,
    output logic             o_one
);

    logic [WIDTH-1:0] w_low_cleared;

    always_comb begin
        o_idx = '0;
        // Scan downward so the lowest set bit is the final assignment.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign w_low_cleared = i_vec & (i_vec - WIDTH'(1));
    assign o_any         = |i_vec;
    assign o_one         = o_any && (w_low_cleared == '0);

endmodule : lsb_prio_enc
`default_nettype wire

// File: rtl/bitscan_encoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bitscan_encoder : serialises a multi-hot vector into set-bit indices, LSB first
// Revision        : 1.0
// ----------------------------------------------------------------------------
module bitscan_encoder
    import bitscan_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_zero,
    output logic [IDX_W:0]   out_cnt
);

    bitscan_state_t         r_state;
    bitscan_state_t         w_state_next;
    logic [WIDTH-1:0]       r_pending;
    logic [IDX_W:0]         r_cnt;

    logic [IDX_W-1:0]       w_idx;
    logic                   w_any;
    logic                   w_one;
    logic                   w_load;
    logic                   w_pop;
    logic [c_POP_MAX_W-1:0] w_pop_vec;
    logic [IDX_W:0]         w_popcnt;

    lsb_prio_enc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_lsb_prio_enc (
        .i_vec (r_pending),
        .o_idx (w_idx),
        .o_any (w_any),
        .o_one (w_one)
    );

    always_comb begin
        w_pop_vec              = '0;
        w_pop_vec[WIDTH-1:0]   = in_data;
    end

    assign w_popcnt = (IDX_W + 1)'(popcount(w_pop_vec));

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_idx      = '0;
        out_last     = 1'b0;
        out_zero     = 1'b0;
        w_load       = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = (in_data != '0) ? SCAN : ZERO;
                end
            end
            SCAN: begin
                out_valid = w_any;
                out_idx   = w_idx;
                out_last  = w_one;
                if (out_ready) begin
                    w_pop = 1'b1;
                    if (w_one) begin
                        w_state_next = IDLE;
                    end
                end
            end
            ZERO: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_zero  = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_pending <= in_data;
                r_cnt     <= w_popcnt;
            end else if (w_pop) begin
                r_pending <= r_pending & (r_pending - WIDTH'(1));
            end
        end
    end

    assign out_cnt = r_cnt;

endmodule : bitscan_encoder
`default_nettype wire

// File: tb/tb_bitscan_encoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bitscan_encoder : randomized bench against a set-bit list reference model
// Revision           : 1.0
// ----------------------------------------------------------------------------
module tb_bitscan_encoder;

    localparam int c_WIDTH = 32;
    localparam int c_IDX_W = 5;

    logic               clk;
    logic               reset_n;
    logic               in_valid;
    logic               in_ready;
    logic [c_WIDTH-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [c_IDX_W-1:0] out_idx;
    logic               out_last;
    logic               out_zero;
    logic [c_IDX_W:0]   out_cnt;

    int n_checks;
    int n_errors;

    bitscan_encoder #(
        .WIDTH (c_WIDTH),
        .IDX_W (c_IDX_W)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_zero  (out_zero),
        .out_cnt   (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Wait (at negedges) for in_ready, bounded.
    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
    endtask

    // Offer vector v, then consume every beat. The first n_hold beat cycles
    // are stalled, afterwards out_ready is low with probability stall_pct.
    task automatic run_vector(input logic [c_WIDTH-1:0] v, input int stall_pct, input int n_hold);
        int exp_idx[$];
        int n_beats;
        int b;
        int cyc;
        int exp_cnt;
        logic rdy;

        for (int i = 0; i < c_WIDTH; i++) begin
            if (v[i]) exp_idx.push_back(i);
        end
        exp_cnt = exp_idx.size();
        n_beats = (exp_cnt == 0) ? 1 : exp_cnt;

        @(negedge clk);
        wait_ready();
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);

        b   = 0;
        cyc = 0;
        while (b < n_beats && cyc < 1000) begin
            rdy       = (cyc >= n_hold) && ($urandom_range(99) >= stall_pct);
            out_ready = rdy;
            // Junk offered while scanning must be ignored.
            in_valid  = $urandom_range(1);
            in_data   = $urandom;
            check_eq("out_valid", 64'(out_valid), 64'd1);
            check_eq("in_ready_busy", 64'(in_ready), 64'd0);
            check_eq("out_idx", 64'(out_idx), (exp_cnt == 0) ? 64'd0 : 64'(exp_idx[b]));
            check_eq("out_last", 64'(out_last), 64'(b == n_beats - 1));
            check_eq("out_zero", 64'(out_zero), 64'(exp_cnt == 0));
            check_eq("out_cnt", 64'(out_cnt), 64'(exp_cnt));
            @(negedge clk);
            if (rdy) b++;
            cyc++;
        end
        check_eq("beat_timeout", 64'(b), 64'(n_beats));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("post_out_valid", 64'(out_valid), 64'd0);
        check_eq("post_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [c_WIDTH-1:0] v;
        n_checks  = 0;
        n_errors  = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_idx", 64'(out_idx), 64'd0);
        check_eq("rst_out_last", 64'(out_last), 64'd0);
        check_eq("rst_out_zero", 64'(out_zero), 64'd0);
        check_eq("rst_out_cnt", 64'(out_cnt), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);

        run_vector(32'h0000_8421, 0, 0);
        run_vector(32'h0000_0000, 0, 0);
        run_vector(32'hFFFF_FFFF, 0, 0);
        run_vector(32'h8000_0001, 0, 3);
        run_vector(32'h0000_0001, 0, 0);
        run_vector(32'h8000_0000, 30, 0);

        // Asynchronous reset part way through a scan.
        @(negedge clk);
        wait_ready();
        in_valid = 1'b1;
        in_data  = 32'h0000_00F0;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("mid_first_idx", 64'(out_idx), 64'd4);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("mid_second_idx", 64'(out_idx), 64'd5);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_out_valid", 64'(out_valid), 64'd0);
        check_eq("async_in_ready", 64'(in_ready), 64'd1);
        check_eq("async_out_cnt", 64'(out_cnt), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_vector(32'h0000_0002, 0, 0);

        for (int t = 0; t < 200; t++) begin
            case ($urandom_range(3))
                0:       v = $urandom;
                1:       v = $urandom & $urandom & $urandom;
                2:       v = c_WIDTH'(1) << $urandom_range(c_WIDTH - 1);
                default: v = ($urandom_range(3) == 0) ? '0 : ~($urandom & $urandom);
            endcase
            run_vector(v, $urandom_range(50), $urandom_range(2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_bitscan_encoder
`default_nettype wire
